audio_serial_master: RTL and testbench
======================================

// Module: audio_serial_master
// PURPOSE
//  Clock-master end of the codec's left-justified serial audio link: generates BCLK and LRCK from CLOCK_50,
//  serializes a stereo sample onto sdata_out (drives the audio controller's ADCDAT input) and deserializes
//  sdata_in (driven by the controller's DACDAT). Serves as the on-chip codec emulator for loopback tests
//  and as the master driver for external slave-mode DACs.
// PARAMETERS
//  DATA_WIDTH  10  bits per channel sample, MSB first
//  SLOT_BITS   32  BCLK periods per channel (LRCK half-period); must be >= DATA_WIDTH
//  BCLK_HALF   8   CLOCK_50 cycles per BCLK half-period (default frame rate 50 MHz/1024 = 48.8 kHz)
// PORTS
//  CLOCK_50       in   1           system clock
//  reset          in   1           asynchronous, active-high reset
//  enable         in   1           run link; low = park in IDLE after current frame
//  tx_left_data   in   DATA_WIDTH  left sample to transmit
//  tx_right_data  in   DATA_WIDTH  right sample to transmit
//  tx_valid       in   1           tx sample pair offered
//  tx_ready       out  1           holding register empty; accepts pair when tx_valid & tx_ready
//  tx_underrun    out  1           1-cycle pulse: frame started with holding register empty
//  rx_left_data   out  DATA_WIDTH  last received left sample
//  rx_right_data  out  DATA_WIDTH  last received right sample
//  rx_valid       out  1           1-cycle pulse: new rx pair on rx_*_data
//  frame_start    out  1           1-cycle pulse at each LRCK rising (left slot start)
//  bclk           out  1           bit clock
//  lrclk          out  1           1 = left slot, 0 = right slot
//  sdata_out      out  1           serial data, changes on BCLK falling edge
//  sdata_in       in   1           serial data, sampled on BCLK rising edge
// BEHAVIOUR
//  Reset: bclk=0, lrclk=0, sdata_out=0, tx_ready=1, tx_underrun=0, rx_*_data=0, rx_valid=0,
//   frame_start=0, state=IDLE, holding/shift regs and counters cleared. Reset mid-frame aborts immediately.
//  States: IDLE, LEFT, RIGHT. IDLE: divider held at 0, bclk=0, lrclk=0, sdata_out=0.
//  IDLE & enable=1 -> LEFT on that clock ("frame event"): lrclk<=1, bit_idx<=0, div<=0, frame_start pulse,
//   shift regs load from holding reg, sdata_out<=left MSB.
//  Divider div counts 0..BCLK_HALF-1; at div==BCLK_HALF-1: if bclk=0 -> rising event (bclk<=1, sample
//   sdata_in if bit_idx<DATA_WIDTH); if bclk=1 -> falling event (bclk<=0, bit_idx++ and shift next bit).
//  sdata_out = data bit (DATA_WIDTH-1-bit_idx) for bit_idx<DATA_WIDTH, else 0 (zero-padded slot).
//  Falling event with bit_idx==SLOT_BITS-1: LEFT -> RIGHT (lrclk<=0, bit_idx<=0, right MSB out);
//   RIGHT -> frame event (LEFT) if enable=1, else IDLE (lrclk=0, bclk=0, sdata_out=0).
//  enable falling mid-frame: current frame completes, including rx delivery; then IDLE.
//  TX holding reg: tx_valid & tx_ready loads both channels, tx_ready<=0 next cycle. At frame event: if full,
//   pair moves to shift regs, tx_ready<=1 next cycle; if empty, zeros sent and tx_underrun pulses.
//   Accept and frame event in the same cycle: frame sees empty (underrun), accepted pair held for next frame.
//  RX: left bits captured in LEFT, right bits in RIGHT. At end of RIGHT (the falling event above), both
//   captured words are copied to rx_*_data and rx_valid pulses 1 cycle later; outputs hold until next pulse.
//  Frame length = 2*SLOT_BITS*2*BCLK_HALF CLOCK_50 cycles (1024 at defaults); first rx_valid follows
//   first frame event by 1024 cycles.
// TESTING
//  Reset release, enable=0 for 200 cycles -> bclk/lrclk/sdata_out stay 0, tx_ready=1, no pulses.
//  Loopback sdata_out->sdata_in, push L=10'h2A5 R=10'h15A then enable=1 -> rx_valid 1024 cycles after
//   frame_start with rx_left=10'h2A5, rx_right=10'h15A; bclk period 16, lrclk high 512 cycles.
//  enable=1 with no tx push -> tx_underrun pulse at each frame_start, sdata_out all 0, loopback rx=0.
//  Push pair every frame (tx_valid held, new data on tx_ready) for 4 frames -> no underrun, rx_valid
//   returns each pair in order, one frame late; bits DATA_WIDTH..31 of each slot are 0 on sdata_out.
//  Drop enable mid-LEFT -> frame completes, rx_valid pulses once, then IDLE with lrclk=0, bclk=0.
//  Assert reset mid-RIGHT -> same cycle outputs return to reset values; re-enable restarts at LEFT MSB.

Source files
------------

// File: rtl/audio_serial_master.sv
// Clock-master end of a left-justified serial audio link: generates BCLK/LRCK from CLOCK_50,
// shifts a stereo pair out MSB-first on sdata_out and captures the returning pair from sdata_in.
`timescale 1ns/1ps

module audio_serial_master #(
    parameter int DATA_WIDTH = 10,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_HALF  = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tx_left_data,
    input  logic [DATA_WIDTH-1:0] tx_right_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_left_data,
    output logic [DATA_WIDTH-1:0] rx_right_data,
    output logic                  rx_valid,
    output logic                  frame_start,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata_out,
    input  logic                  sdata_in
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int IDX_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLOT_BITS - 1);
    localparam logic [IDX_W:0]   DW_BITS  = (IDX_W + 1)'(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_bclk, r_lrclk, r_sdata;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_l, r_hold_r;
    logic [DATA_WIDTH-1:0] r_tx_l, r_tx_r;
    logic [DATA_WIDTH-1:0] r_rx_l, r_rx_r;
    logic [DATA_WIDTH-1:0] r_rx_left_out, r_rx_right_out;
    logic                  r_rx_valid, r_frame_start, r_tx_underrun;

    logic w_div_end, w_rise, w_fall, w_slot_end, w_frame_end, w_frame_event, w_capture;

    assign w_div_end     = (r_state != S_IDLE) && (r_div == DIV_LAST);
    assign w_rise        = w_div_end && !r_bclk;
    assign w_fall        = w_div_end && r_bclk;
    assign w_slot_end    = w_fall && (r_bit_idx == IDX_LAST);
    assign w_frame_end   = w_slot_end && (r_state == S_RIGHT);
    assign w_frame_event = enable && ((r_state == S_IDLE) || w_frame_end);
    assign w_capture     = w_rise && ({1'b0, r_bit_idx} < DW_BITS);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (enable)      w_next_state = S_LEFT;
            S_LEFT:  if (w_slot_end)  w_next_state = S_RIGHT;
            S_RIGHT: if (w_frame_end) w_next_state = enable ? S_LEFT : S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_div          <= '0;
            r_bit_idx      <= '0;
            r_bclk         <= 1'b0;
            r_lrclk        <= 1'b0;
            r_sdata        <= 1'b0;
            r_hold_full    <= 1'b0;
            r_hold_l       <= '0;
            r_hold_r       <= '0;
            r_tx_l         <= '0;
            r_tx_r         <= '0;
            r_rx_l         <= '0;
            r_rx_r         <= '0;
            r_rx_left_out  <= '0;
            r_rx_right_out <= '0;
            r_rx_valid     <= 1'b0;
            r_frame_start  <= 1'b0;
            r_tx_underrun  <= 1'b0;
        end else begin
            r_frame_start <= w_frame_event;
            r_tx_underrun <= w_frame_event && !r_hold_full;
            r_rx_valid    <= w_frame_end;
            if (w_frame_end) begin
                r_rx_left_out  <= r_rx_l;
                r_rx_right_out <= r_rx_r;
            end

            // A pair accepted on the frame-event edge is not yet visible to that frame.
            if (w_frame_event && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (tx_valid && !r_hold_full) begin
                r_hold_full <= 1'b1;
                r_hold_l    <= tx_left_data;
                r_hold_r    <= tx_right_data;
            end

            if (w_frame_event) begin
                r_div     <= '0;
                r_bclk    <= 1'b0;
                r_lrclk   <= 1'b1;
                r_bit_idx <= '0;
                r_tx_l    <= r_hold_full ? r_hold_l : '0;
                r_tx_r    <= r_hold_full ? r_hold_r : '0;
                r_sdata   <= r_hold_full && r_hold_l[DATA_WIDTH-1];
            end else if (r_state != S_IDLE) begin
                r_div <= w_div_end ? '0 : r_div + 1'b1;
                if (w_rise) begin
                    r_bclk <= 1'b1;
                    if (w_capture && r_state == S_LEFT)  r_rx_l <= {r_rx_l[DATA_WIDTH-2:0], sdata_in};
                    if (w_capture && r_state == S_RIGHT) r_rx_r <= {r_rx_r[DATA_WIDTH-2:0], sdata_in};
                end
                if (w_fall) begin
                    r_bclk <= 1'b0;
                    if (r_bit_idx == IDX_LAST) begin
                        r_bit_idx <= '0;
                        r_lrclk   <= 1'b0;
                        r_sdata   <= (r_state == S_LEFT) ? r_tx_r[DATA_WIDTH-1] : 1'b0;
                    end else begin
                        // Zeros shift in, so the slot pads with 0 once the sample is exhausted.
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_state == S_LEFT) begin
                            r_tx_l  <= {r_tx_l[DATA_WIDTH-2:0], 1'b0};
                            r_sdata <= r_tx_l[DATA_WIDTH-2];
                        end else begin
                            r_tx_r  <= {r_tx_r[DATA_WIDTH-2:0], 1'b0};
                            r_sdata <= r_tx_r[DATA_WIDTH-2];
                        end
                    end
                end
            end
        end
    end

    assign tx_ready      = !r_hold_full;
    assign tx_underrun   = r_tx_underrun;
    assign rx_left_data  = r_rx_left_out;
    assign rx_right_data = r_rx_right_out;
    assign rx_valid      = r_rx_valid;
    assign frame_start   = r_frame_start;
    assign bclk          = r_bclk;
    assign lrclk         = r_lrclk;
    assign sdata_out     = r_sdata;

endmodule

// File: tb/tb_audio_serial_master.sv
// Loopback bench for audio_serial_master: transaction-level scoreboard of sent/received pairs
// plus independent checks of the serial slot format and link timing.
`timescale 1ns/1ps

module tb_audio_serial_master;

    localparam int DW    = 10;
    localparam int SLOT  = 32;
    localparam int HALF  = 8;
    localparam int FRAME = 2 * SLOT * 2 * HALF;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] tx_left_data, tx_right_data;
    logic          tx_valid;
    logic          tx_ready, tx_underrun;
    logic [DW-1:0] rx_left_data, rx_right_data;
    logic          rx_valid, frame_start, bclk, lrclk, sdata_out, sdata_in;

    assign sdata_in = sdata_out;

    audio_serial_master #(.DATA_WIDTH(DW), .SLOT_BITS(SLOT), .BCLK_HALF(HALF)) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .enable        (enable),
        .tx_left_data  (tx_left_data),
        .tx_right_data (tx_right_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_underrun   (tx_underrun),
        .rx_left_data  (rx_left_data),
        .rx_right_data (rx_right_data),
        .rx_valid      (rx_valid),
        .frame_start   (frame_start),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata_out     (sdata_out),
        .sdata_in      (sdata_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {25'b0, bclk, lrclk, sdata_out, tx_ready, tx_underrun, rx_valid, frame_start},
              32'h0000_0008);
        check({tag, "_rx"}, {12'b0, rx_left_data, rx_right_data}, 32'h0);
    endtask

    // Scoreboard model: pairs accepted before a frame event are sent in that frame and,
    // through the loopback, come back on rx at the end of the same frame.
    pair_t       ready_q[$];
    pair_t       exp_rx[$];
    int          fs_time_q[$];
    pair_t       just_acc, cur, e;
    logic        just_acc_vld;
    logic        prev_bclk, prev_lrclk;
    int          lr_rise, last_rise, slot_bits, t;
    logic [31:0] slot_word, exp_word;
    int          exp_underruns = 0, act_underruns = 0;

    always @(negedge clk) begin
        if (reset) begin
            ready_q.delete();
            exp_rx.delete();
            fs_time_q.delete();
            just_acc_vld = 1'b0;
            prev_bclk    = 1'b0;
            prev_lrclk   = 1'b0;
            slot_bits    = 0;
            slot_word    = '0;
            last_rise    = -1000;
            lr_rise      = 0;
            cur          = '0;
        end else begin
            if (tx_underrun) act_underruns++;
            if (frame_start) begin
                fs_time_q.push_back(cyc);
                if (ready_q.size() > 0) begin
                    cur = ready_q.pop_front();
                    check("underrun_flag", 32'(tx_underrun), 32'd0);
                end else begin
                    cur = '0;
                    exp_underruns++;
                    check("underrun_flag", 32'(tx_underrun), 32'd1);
                end
                exp_rx.push_back(cur);
                check("frame_lrclk", 32'(lrclk), 32'd1);
            end
            if (just_acc_vld) ready_q.push_back(just_acc);
            just_acc_vld = tx_valid && tx_ready;
            just_acc     = {tx_left_data, tx_right_data};

            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    check("rx_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_rx.pop_front();
                    t = fs_time_q.pop_front();
                    check("rx_left", 32'(rx_left_data), 32'(e.l));
                    check("rx_right", 32'(rx_right_data), 32'(e.r));
                    check("rx_latency", cyc - t, FRAME);
                end
            end

            if (lrclk != prev_lrclk) begin
                if (!lrclk) check("lrclk_high", cyc - lr_rise, FRAME / 2);
                else        lr_rise = cyc;
                slot_bits = 0;
                slot_word = '0;
            end
            if (bclk && !prev_bclk) begin
                if (cyc - last_rise <= 4 * HALF) check("bclk_period", cyc - last_rise, 2 * HALF);
                last_rise = cyc;
                slot_word = {slot_word[30:0], sdata_out};
                slot_bits++;
                if (slot_bits == SLOT) begin
                    exp_word = lrclk ? {cur.l, {(SLOT-DW){1'b0}}} : {cur.r, {(SLOT-DW){1'b0}}};
                    check(lrclk ? "slot_left" : "slot_right", slot_word, exp_word);
                    slot_bits = 0;
                end
            end
            prev_bclk  = bclk;
            prev_lrclk = lrclk;
        end
    end

    task automatic wait_fs(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!frame_start && n < 2 * FRAME);
        if (!frame_start) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!rx_valid && n < 2 * FRAME);
        if (!rx_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int n = 0;
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_left_data = l; tx_right_data = r;
        do begin @(negedge clk); n++; end while (!tx_ready && n < 3 * FRAME);
        if (!tx_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic stream_frames(input int nf);
        int   seen = 0, budget = 0, unders = 0;
        logic fire;
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_left_data = DW'($urandom); tx_right_data = DW'($urandom);
        while (seen < nf && budget < (nf + 1) * FRAME) begin
            @(negedge clk); budget++;
            fire = tx_ready;
            if (frame_start) begin
                seen++;
                if (tx_underrun) unders++;
            end
            @(posedge clk); #1;
            if (fire) begin tx_left_data = DW'($urandom); tx_right_data = DW'($urandom); end
        end
        tx_valid = 1'b0;
        if (seen < nf) check("stream_timeout", 32'(seen), 32'(nf));
        check("stream_no_underrun", 32'(unders), 32'd0);
    endtask

    task automatic random_frames(input int nf);
        int   seen = 0, budget = 0;
        logic fire;
        while (seen < nf && budget < (nf + 1) * FRAME) begin
            @(negedge clk); budget++;
            fire = tx_valid && tx_ready;
            if (frame_start) seen++;
            @(posedge clk); #1;
            if (fire) tx_valid = 1'b0;
            if (!tx_valid && $urandom_range(0, 999) < 2) begin
                tx_valid = 1'b1; tx_left_data = DW'($urandom); tx_right_data = DW'($urandom);
            end
        end
        tx_valid = 1'b0;
        if (seen < nf) check("random_timeout", 32'(seen), 32'(nf));
    endtask

    logic idle_bad;
    int   rx_pulses, fs_pulses;

    initial begin
        reset = 1'b1; enable = 1'b0; tx_valid = 1'b0; tx_left_data = '0; tx_right_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1; reset = 1'b0;

        // Disabled link stays parked.
        idle_bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            idle_bad |= bclk | lrclk | sdata_out | !tx_ready | tx_underrun | rx_valid | frame_start;
        end
        check("idle_quiet", 32'(idle_bad), 32'd0);

        // Directed loopback pair, then frames with nothing offered (underruns, zero data).
        push(10'h2A5, 10'h15A);
        enable = 1'b1;
        wait_fs("first_frame");
        check("first_msb", 32'(sdata_out), 32'd1);
        wait_rx("first_rx");
        wait_fs("underrun_frame");
        wait_fs("underrun_frame2");

        stream_frames(4);
        random_frames(5);

        // Drop enable mid-LEFT: the frame completes and the link parks.
        wait_fs("drop_frame");
        repeat (200) @(negedge clk);
        check("drop_in_left", 32'(lrclk), 32'd1);
        enable = 1'b0;
        rx_pulses = 0; fs_pulses = 0;
        repeat (FRAME + 100) begin
            @(negedge clk);
            rx_pulses += 32'(rx_valid);
            fs_pulses += 32'(frame_start);
        end
        check("drop_rx_once", 32'(rx_pulses), 32'd1);
        check("drop_no_new_frame", 32'(fs_pulses), 32'd0);
        check("drop_parked", {29'b0, bclk, lrclk, sdata_out}, 32'd0);

        // Reset mid-RIGHT aborts at once; re-enable restarts at the left MSB.
        enable = 1'b1;
        push(DW'($urandom), DW'($urandom));
        wait_fs("pre_reset_frame");
        repeat (600) @(negedge clk);
        check("reset_in_right", 32'(lrclk), 32'd0);
        #2; reset = 1'b1; enable = 1'b0;
        #1; check_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        push(10'h3C3, 10'h0F0);
        enable = 1'b1;
        wait_fs("restart_frame");
        check("restart_msb", {30'b0, lrclk, sdata_out}, 32'd3);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        repeat (FRAME + 100) @(negedge clk);

        check("rx_all_delivered", 32'(exp_rx.size()), 32'd0);
        check("underrun_total", 32'(act_underruns), 32'(exp_underruns));
        check("final_parked", {29'b0, bclk, lrclk, sdata_out}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
